// File: rtl/color_pkg.sv
// Shared definitions for the colour sensor link: select encoding, default
// counter width and the wave generator state encoding.
package color_pkg;

  localparam int COLOR_HW = 16;

  // Filter select encoding shared with the colour receiver
  localparam logic [1:0] SEL_RED   = 2'b00;
  localparam logic [1:0] SEL_BLUE  = 2'b01;
  localparam logic [1:0] SEL_CLEAR = 2'b10;
  localparam logic [1:0] SEL_GREEN = 2'b11;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'b00,
    ST_HIGH   = 2'b01,
    ST_LOW    = 2'b10,
    ST_OFF    = 2'b11
  } wave_state_t;

  // A settle length of 0 behaves as 1 so the FSM always passes through SETTLE
  function automatic int settle_len(input int cyc);
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/color_period_regs.sv
// Four-entry half-period register bank, one entry per filter select.
// Writes land on the next edge; the read port is combinational.
module color_period_regs
  import color_pkg::*;
#(
  parameter int HW         = COLOR_HW,
  parameter int HALF_RED   = 250,
  parameter int HALF_BLUE  = 400,
  parameter int HALF_CLEAR = 100,
  parameter int HALF_GREEN = 300
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [HW-1:0] wr_data,
  input  logic [1:0]    rd_addr,
  output logic [HW-1:0] rd_data
);

  logic [HW-1:0] half_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      half_q[SEL_RED]   <= HW'(HALF_RED);
      half_q[SEL_BLUE]  <= HW'(HALF_BLUE);
      half_q[SEL_CLEAR] <= HW'(HALF_CLEAR);
      half_q[SEL_GREEN] <= HW'(HALF_GREEN);
    end else if (wr_en) begin
      half_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = half_q[rd_addr];

endmodule

// File: rtl/color_wave_gen.sv
// Colour sensor frequency-output emulator: 50% duty square wave whose
// half-period is selected by the receiver's 2-bit filter select.
//
// state  | meaning
// SETTLE | output held low after reset or a select change
// HIGH   | wave high, counting the half-period down
// LOW    | wave low, counting the half-period down
// OFF    | selected channel has half-period 0; wave parked low
module color_wave_gen
  import color_pkg::*;
#(
  parameter int HW         = COLOR_HW,
  parameter int HALF_RED   = 250,
  parameter int HALF_BLUE  = 400,
  parameter int HALF_CLEAR = 100,
  parameter int HALF_GREEN = 300,
  parameter int SETTLE_CYC = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    select,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [HW-1:0] wr_data,
  output logic          wave,
  output logic          settled,
  output logic [HW-1:0] edge_cnt
);

  localparam int            SETTLE_LEN  = settle_len(SETTLE_CYC);
  localparam logic [HW-1:0] SETTLE_LOAD = HW'(SETTLE_LEN - 1);
  localparam logic [HW-1:0] ONE         = HW'(1);

  wave_state_t   state_q, state_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] edge_q, edge_d;
  logic [1:0]    sel_q;
  logic [HW-1:0] half_cur;
  logic          sel_chg, cnt_tc, half_zero, wake;

  color_period_regs #(
    .HW         (HW),
    .HALF_RED   (HALF_RED),
    .HALF_BLUE  (HALF_BLUE),
    .HALF_CLEAR (HALF_CLEAR),
    .HALF_GREEN (HALF_GREEN)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (sel_q),
    .rd_data (half_cur)
  );

  assign sel_chg   = (select != sel_q);
  assign cnt_tc    = (cnt_q == '0);
  assign half_zero = (half_cur == '0);
  // Only a nonzero write to the parked channel can bring it back
  assign wake      = wr_en && (wr_addr == sel_q) && (wr_data != '0);

  // Counter holds remaining cycles minus one, so terminal count is zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    if (sel_chg) begin
      state_d = ST_SETTLE;
      cnt_d   = SETTLE_LOAD;
    end else begin
      case (state_q)
        ST_SETTLE, ST_LOW: begin
          if (cnt_tc) begin
            if (half_zero) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_HIGH;
              cnt_d   = half_cur - ONE;
              edge_d  = edge_q + ONE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_tc) begin
            if (half_zero) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_LOW;
              cnt_d   = half_cur - ONE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        ST_OFF: begin
          if (wake) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end
        default: begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SETTLE;
      cnt_q   <= SETTLE_LOAD;
      edge_q  <= '0;
      sel_q   <= select;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sel_q   <= select;
    end
  end

  assign wave     = (state_q == ST_HIGH);
  assign settled  = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign edge_cnt = edge_q;

endmodule

// File: doc/color_wave_gen.md
Name: color_wave_gen

Overview:
- Synthesizable emulator of the colour sensor's frequency output: the transmitting end of the select/square-wave link used by the colour receiver logic.
- Drives a 50% duty square wave whose half-period depends on the 2-bit filter select from the receiver.
- Two uses: on-board hardware-in-the-loop runs with sensors unplugged, and a bench stimulus for the colour receiver.
- Half-periods have reset defaults and can be rewritten at run time through a simple write port.

Parameters:
- HW, 16, width of half-period values and internal counters.
- HALF_RED, 250, reset half-period in clk cycles for select 2'b00.
- HALF_BLUE, 400, reset half-period for select 2'b01.
- HALF_CLEAR, 100, reset half-period for select 2'b10.
- HALF_GREEN, 300, reset half-period for select 2'b11.
- SETTLE_CYC, 50, cycles the output is held low after a select change (values 0 and 1 both mean 1 cycle).

Ports:
- clk  input  1  50 MHz system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- select  input  2  filter select from the receiver (00 red, 01 blue, 10 clear, 11 green).
- wr_en  input  1  write strobe for the half-period registers.
- wr_addr  input  2  channel index being written.
- wr_data  input  HW  new half-period in clk cycles; 0 disables the channel.
- wave  output  1  emulated sensor square wave.
- settled  output  1  high while in HIGH/LOW, i.e. producing a valid wave for the current select.
- edge_cnt  output  HW  count of rising edges on wave; wraps modulo 2^HW.

Behaviour:
- All registers update on posedge clk. rst is synchronous, active-high and takes priority over everything else.
- Reset state:
  - wave=0, settled=0, edge_cnt=0.
  - Half-period registers = HALF_* defaults.
  - sel_q = select as sampled in the reset cycle.
  - FSM state = SETTLE with settle counter loaded.
- FSM states: SETTLE, HIGH, LOW, OFF.
- SETTLE:
  - wave=0, settled=0.
  - Counts max(SETTLE_CYC,1) cycles.
  - At the end: if half[sel_q]==0, go to OFF; otherwise go to HIGH and load the counter with half[sel_q].
- HIGH:
  - wave=1 for exactly half[sel_q] cycles, then LOW. The rising edge increments edge_cnt in the same cycle wave goes high.
- LOW:
  - wave=0 for exactly half cycles, then HIGH.
  - Full period = 2*half cycles.
- OFF:
  - wave=0, settled=0.
  - Stays here until select changes or the current channel is written with a nonzero value; either event enters SETTLE.
- Select change:
  - select != sel_q in any state causes sel_q<=select and SETTLE (counter reloaded) on the next edge.
  - wave=0 from the next cycle, even if it was mid-HIGH.
  - A change during SETTLE restarts SETTLE.
- Writes:
  - A write updates half[wr_addr] in the following cycle.
  - A write to the active channel does not disturb the running count; the new value is used at the next HIGH/LOW reload.
  - Writing 0 to the active channel makes the FSM go to OFF at the next reload boundary instead of HIGH/LOW.
- Simultaneous write and select change: both take effect. SETTLE uses the new sel_q, and the first HIGH uses the freshly written value if wr_addr matches.
- Half-period of 1 gives wave toggling every cycle (period 2 cycles). The maximum value is 2^HW-1; there is no overflow because the counter counts down from the loaded value.
- Reset asserted mid-HIGH: wave=0 on the next edge; defaults restored; sequence restarts with SETTLE.

Decomposition:
- Shared package `color_pkg`:
  - Select encoding constants SEL_RED/SEL_BLUE/SEL_CLEAR/SEL_GREEN, also used by the colour receiver.
  - HW width constant.
  - FSM state encoding.
- One sub-module, `color_period_regs`: the 4-entry half-period register bank with reset defaults and write port; combinational read by sel_q.
- FSM, counters and edge counter stay in color_wave_gen.

Test Plan:
- Reset, select=00, defaults:
  - wave low for 50 cycles, settled=0.
  - Then 250 high / 250 low repeating; settled=1 from the first high cycle.
  - edge_cnt=4 after 4 rising edges.
- Select 00->10 mid-HIGH (cycle 100 of 250): wave=0 the next cycle, 50 cycles low, then 100/100 periods.
- Write addr 2 data 20 while select=10 mid-LOW: the current low phase still completes 100 cycles; subsequent phases are 20 cycles.
- Write addr 1 data 0, then select 01: 50 settle cycles, then OFF with wave=0 and settled=0 held indefinitely. Then write addr 1 data 8: SETTLE again, then 8/8 wave.
- Same-cycle select 00->11 and write addr 3 data 5: after settling, the first high phase is exactly 5 cycles.
- SETTLE_CYC=0 and half=1: wave toggles every cycle after a 1-cycle settle. Run 65537 rising edges: edge_cnt wraps to 1.
